// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants, FSM state encoding and small helpers for the UART command controller.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CHK,
    ST_EXEC,
    ST_RESP,
    ST_WAIT_TX
  } cmd_state_e;

  function automatic logic frame_valid(input logic [7:0] cmd, input logic [7:0] addr,
                                       input logic [7:0] data, input logic [7:0] chk);
    return (chk == (cmd ^ addr ^ data)) && ((cmd == CMD_WR) || (cmd == CMD_RD));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// UART byte stream, register-file bus and status lines of the command controller.
interface uart_cmd_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              reg_ack;
  logic              busy;
  logic              err_chk;
  logic              err_timeout;

  modport master (
    input  rx_data, rx_done, tx_done, reg_rdata, reg_ack,
    output tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re, busy, err_chk, err_timeout
  );

  modport slave (
    output rx_data, rx_done, tx_done, reg_rdata, reg_ack,
    input  tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re, busy, err_chk, err_timeout
  );
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: clr restarts, en counts, expire flags the cycle whose
// clock edge would bring the count to TIMEOUT_CYCLES-1 (requires TIMEOUT_CYCLES >= 2).
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: SYNC/CMD/ADDR/DATA/CHK frames -> register access -> 1-byte reply.
// Optional statistics counters (frame_cnt, err_cnt) under `define UART_CMD_STATS_EN.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_ctrl_if.master  bus
`ifdef UART_CMD_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt
`endif
);

  cmd_state_e        state_q;
  logic [7:0]        cmd_q, addr_q, data_q, tx_data_q, reg_wdata_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic              tx_start_q, reg_we_q, reg_re_q, busy_q, err_chk_q, err_to_q;
  logic              tmr_en, tmr_expire, chk_ok;

  assign tmr_en = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR) ||
                  (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK);
  assign chk_ok = frame_valid(cmd_q, addr_q, data_q, bus.rx_data);

  // Every received byte restarts the timer; in IDLE the count is simply ignored.
  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (bus.rx_done),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      tx_start_q  <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      err_chk_q  <= 1'b0;
      err_to_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_done && (bus.rx_data == SYNC_BYTE)) begin
            state_q <= ST_GET_CMD;
            busy_q  <= 1'b1;
          end
        end
        // A byte arriving on the expiry cycle takes priority over the abort.
        ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA: begin
          if (bus.rx_done) begin
            if (state_q == ST_GET_CMD) begin
              cmd_q   <= bus.rx_data;
              state_q <= ST_GET_ADDR;
            end else if (state_q == ST_GET_ADDR) begin
              addr_q  <= bus.rx_data;
              state_q <= ST_GET_DATA;
            end else begin
              data_q  <= bus.rx_data;
              state_q <= ST_GET_CHK;
            end
          end else if (tmr_expire) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            err_to_q <= 1'b1;
          end
        end
        ST_GET_CHK: begin
          if (bus.rx_done) begin
            if (chk_ok) begin
              state_q     <= ST_EXEC;
              reg_we_q    <= (cmd_q == CMD_WR);
              reg_re_q    <= (cmd_q == CMD_RD);
              reg_addr_q  <= addr_q[ADDR_W-1:0];
              reg_wdata_q <= data_q;
            end else begin
              state_q   <= ST_RESP;
              tx_data_q <= RSP_NAK;
              err_chk_q <= 1'b1;
            end
          end else if (tmr_expire) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            err_to_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (bus.reg_ack) begin
            state_q   <= ST_RESP;
            reg_we_q  <= 1'b0;
            reg_re_q  <= 1'b0;
            tx_data_q <= reg_re_q ? bus.reg_rdata : RSP_ACK;
          end
        end
        ST_RESP: begin
          tx_start_q <= 1'b1;
          state_q    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (bus.tx_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wdata   = reg_wdata_q;
  assign bus.reg_we      = reg_we_q;
  assign bus.reg_re      = reg_re_q;
  assign bus.busy        = busy_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_timeout = err_to_q;

`ifdef UART_CMD_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if ((state_q == ST_GET_CHK) && bus.rx_done && chk_ok) begin
        frame_cnt_q <= sat_inc16(frame_cnt_q);
      end
      if (err_chk_q || err_to_q) begin
        err_cnt_q <= sat_inc16(err_cnt_q);
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: directed frames, responders for register and UART tx.
module tb_uart_cmd_ctrl;
  import uart_cmd_ctrl_pkg::*;

  localparam int TO = 50;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         len;
  } reg_exp_t;

  typedef struct {
    int     kind;   // 0 = checksum/opcode, 1 = timeout
    longint due;    // negedge time at which the pulse must be seen
  } err_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_ctrl_if #(.ADDR_W(8)) bus ();

`ifdef UART_CMD_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UART_CMD_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_tx[$];
  reg_exp_t   exp_reg[$];
  err_exp_t   exp_err[$];

  int         ack_dly = 3;
  logic [7:0] rd_val  = 8'h00;
  bit         no_ack  = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry queued (t=%0t)", name, $time);
  endfunction

  // Register-file responder
  initial begin
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if ((bus.reg_we || bus.reg_re) && !no_ack && !rst) begin
        repeat (ack_dly - 1) @(posedge clk);
        #1 bus.reg_ack = 1'b1;
        bus.reg_rdata = rd_val;
        @(posedge clk);
        #1 bus.reg_ack = 1'b0;
        bus.reg_rdata = 8'hEE;
      end
    end
  end

  // UART transmitter responder
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        repeat (2) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
      end
    end
  end

  // Monitor
  bit       in_req  = 1'b0;
  int       req_len = 0;
  reg_exp_t cur;
  err_exp_t ce;

  always @(negedge clk) begin
    if (rst) begin
      in_req = 1'b0;
    end else begin
      if (bus.tx_start) begin
        if (exp_tx.size() == 0) unexpected("tx_start");
        else check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
      if (bus.reg_we || bus.reg_re) begin
        check("we_re_exclusive", 32'(bus.reg_we & bus.reg_re), 32'd0);
        if (!in_req) begin
          in_req  = 1'b1;
          req_len = 0;
          if (exp_reg.size() == 0) begin
            unexpected("reg_request");
            cur = '{1'b0, 8'h00, 8'h00, 0};
          end else begin
            cur = exp_reg.pop_front();
            check("reg_we", 32'(bus.reg_we), 32'(cur.we));
            check("reg_re", 32'(bus.reg_re), 32'(!cur.we));
            check("reg_addr", 32'(bus.reg_addr), 32'(cur.addr));
            if (cur.we) check("reg_wdata", 32'(bus.reg_wdata), 32'(cur.wdata));
          end
        end
        req_len++;
      end else if (in_req) begin
        check("req_len", 32'(req_len), 32'(cur.len));
        in_req = 1'b0;
      end
      if (bus.err_chk || bus.err_timeout) begin
        if (exp_err.size() == 0) unexpected("err_pulse");
        else begin
          ce = exp_err.pop_front();
          check("err_kind", {30'd0, bus.err_chk, bus.err_timeout},
                (ce.kind == 1) ? 32'd1 : 32'd2);
          check("err_time", 32'($time), 32'(ce.due));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output longint t);
    @(posedge clk);
    #1 bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    t = $time;
    #1 bus.rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] k, output longint t_chk);
    longint t;
    send_byte(SYNC_BYTE, t);
    send_byte(c, t);
    send_byte(a, t);
    send_byte(d, t);
    send_byte(k, t_chk);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200 && bus.busy; i++) @(negedge clk);
    @(negedge clk);
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_data"},   32'(bus.tx_data),     32'd0);
    check({tag, "_tx_start"},  32'(bus.tx_start),    32'd0);
    check({tag, "_reg_addr"},  32'(bus.reg_addr),    32'd0);
    check({tag, "_reg_wdata"}, 32'(bus.reg_wdata),   32'd0);
    check({tag, "_reg_we"},    32'(bus.reg_we),      32'd0);
    check({tag, "_reg_re"},    32'(bus.reg_re),      32'd0);
    check({tag, "_busy"},      32'(bus.busy),        32'd0);
    check({tag, "_err_chk"},   32'(bus.err_chk),     32'd0);
    check({tag, "_err_to"},    32'(bus.err_timeout), 32'd0);
`ifdef UART_CMD_STATS_EN
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, required < 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Write 0x3C to 0x10, ack after 3 cycles
    ack_dly = 3;
    exp_reg.push_back('{1'b1, 8'h10, 8'h3C, 3});
    exp_tx.push_back(RSP_ACK);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D, t);
    wait_idle("wr_busy_done");

    // Read 0x10 returning 0x5A
    ack_dly = 2;
    rd_val  = 8'h5A;
    exp_reg.push_back('{1'b0, 8'h10, 8'h00, 2});
    exp_tx.push_back(8'h5A);
    send_frame(8'h02, 8'h10, 8'h00, 8'h12, t);
    wait_idle("rd_busy_done");

    // Bad checksum, then unknown opcode
    exp_tx.push_back(RSP_NAK);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h00, t);
    exp_err.push_back('{0, t + 5});
    wait_idle("badchk_busy_done");
    exp_tx.push_back(RSP_NAK);
    send_frame(8'h07, 8'h10, 8'h3C, 8'h2B, t);
    exp_err.push_back('{0, t + 5});
    wait_idle("badop_busy_done");

    // Leading garbage, then write 0x11 to 0x20
    send_byte(8'h00, t);
    send_byte(8'hFF, t);
    send_byte(8'h3C, t);
    ack_dly = 1;
    exp_reg.push_back('{1'b1, 8'h20, 8'h11, 1});
    exp_tx.push_back(RSP_ACK);
    send_frame(8'h01, 8'h20, 8'h11, 8'h30, t);
    wait_idle("garbage_busy_done");

    // Timeout after CMD byte
    send_byte(SYNC_BYTE, t);
    send_byte(8'h01, t);
    exp_err.push_back('{1, t + (TO - 1) * 10 + 5});
    repeat (TO + 10) @(posedge clk);
    wait_idle("timeout_idle");

    // Valid read after timeout
    ack_dly = 2;
    rd_val  = 8'hC3;
    exp_reg.push_back('{1'b0, 8'h33, 8'h7E, 2});
    exp_tx.push_back(8'hC3);
    send_frame(8'h02, 8'h33, 8'h7E, 8'h4F, t);
    wait_idle("post_to_busy_done");

    // ADDR byte lands exactly on the expiry cycle
    send_byte(SYNC_BYTE, t);
    send_byte(8'h01, t);
    repeat (TO - 3) @(posedge clk);
    exp_reg.push_back('{1'b1, 8'h44, 8'h99, 2});
    exp_tx.push_back(RSP_ACK);
    send_byte(8'h44, t);
    send_byte(8'h99, t);
    send_byte(8'hDC, t);
    wait_idle("edge_busy_done");

    // Reset while reg_we is held
    no_ack = 1'b1;
    exp_reg.push_back('{1'b1, 8'h55, 8'hAA, 0});
    send_frame(8'h01, 8'h55, 8'hAA, 8'hFE, t);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    no_ack = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    repeat (5) @(negedge clk);
    check("midrst_no_tx", 32'(bus.tx_start), 32'd0);

    ack_dly = 2;
    exp_reg.push_back('{1'b1, 8'h66, 8'h77, 2});
    exp_tx.push_back(RSP_ACK);
    send_frame(8'h01, 8'h66, 8'h77, 8'h10, t);
    wait_idle("after_rst_busy_done");
`ifdef UART_CMD_STATS_EN
    check("stats_frame_cnt", 32'(frame_cnt), 32'd1);
    check("stats_err_cnt",   32'(err_cnt),   32'd0);
`endif

    repeat (5) @(negedge clk);
    check("tx_queue_empty",  32'(exp_tx.size()),  32'd0);
    check("reg_queue_empty", 32'(exp_reg.size()), 32'd0);
    check("err_queue_empty", 32'(exp_err.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
